// File: rtl/data_mem_bridge.sv
// ---------------------------------------------------------------------------
// data_mem_bridge
//
// Purpose:
//   Connects a core's level-style load/store interface to a valid/ready
//   request bus with a one-cycle response pulse. Each core access becomes a
//   single bus transaction. The core stalls on mem_busy until the access
//   retires in DONE. Misaligned accesses are rejected without touching the
//   bus. A response that never arrives is aborted after TIMEOUT_CYCLES.
//
// Handshake:
//   A request transfers on a cycle where bus_req_valid & bus_req_ready are
//   both high. While it waits, addr/write/wdata come from holding registers
//   and do not change. The response is accepted together with the transfer
//   (REQ state) or on any later cycle (RESP state). bus_resp_valid seen in
//   any other state is ignored.
//
// Ports:
//   clk, reset          single clock, synchronous active-high reset
//   data_addr           core data address (must be word aligned)
//   should_read_mem     core load request (level, held until !mem_busy)
//   should_write_mem    core store request (level, wins over read)
//   mem_write_data      core store data
//   mem_read_data       load result / 0 on misalign / DEADBEEF on timeout
//   mem_busy            core stall
//   bus_req_*           request channel to the bus
//   bus_resp_*          response channel from the bus
//   err_sticky          set on any error, cleared only by reset
//   err_code            last error: 00 none, 01 misaligned, 10 timeout
//   dbg_state           current FSM state (0 IDLE, 1 REQ, 2 RESP, 3 DONE)
// ---------------------------------------------------------------------------
module data_mem_bridge #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] data_addr,
   input  logic        should_read_mem,
   input  logic        should_write_mem,
   input  logic [31:0] mem_write_data,
   output logic [31:0] mem_read_data,
   output logic        mem_busy,
   output logic        bus_req_valid,
   input  logic        bus_req_ready,
   output logic [31:0] bus_req_addr,
   output logic        bus_req_write,
   output logic [31:0] bus_req_wdata,
   input  logic        bus_resp_valid,
   input  logic [31:0] bus_resp_rdata,
   output logic        err_sticky,
   output logic [1:0]  err_code,
   output logic [1:0]  dbg_state
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_RESP = 2'd2,
      S_DONE = 2'd3
   } state_t;

   localparam logic [7:0] TIMEOUT_LIM = 8'(TIMEOUT_CYCLES);
   localparam logic [1:0] ERR_MISALIGN = 2'b01;
   localparam logic [1:0] ERR_TIMEOUT  = 2'b10;

   state_t      state_q;
   logic [7:0]  cnt_q;
   logic [7:0]  cnt_d;
   logic [31:0] rdata_q;
   logic [31:0] addr_q;
   logic        write_q;
   logic [31:0] wdata_q;
   logic        err_sticky_q;
   logic [1:0]  err_code_q;

   logic        pending;
   logic        aligned;

   assign pending = should_read_mem | should_write_mem;
   assign aligned = (data_addr[1:0] == 2'b00);
   assign cnt_d   = cnt_q + 8'd1;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= S_IDLE;
         cnt_q        <= 8'd0;
         rdata_q      <= 32'd0;
         addr_q       <= 32'd0;
         write_q      <= 1'b0;
         wdata_q      <= 32'd0;
         err_sticky_q <= 1'b0;
         err_code_q   <= 2'b00;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (pending) begin
                  if (aligned) begin
                     addr_q  <= data_addr;
                     write_q <= should_write_mem;
                     wdata_q <= mem_write_data;
                     state_q <= S_REQ;
                  end else begin
                     rdata_q      <= 32'd0;
                     err_sticky_q <= 1'b1;
                     err_code_q   <= ERR_MISALIGN;
                     state_q      <= S_DONE;
                  end
               end
            end
            S_REQ: begin
               if (bus_req_ready) begin
                  // A response in the same cycle as the handshake completes the access.
                  if (bus_resp_valid) begin
                     if (!write_q) begin
                        rdata_q <= bus_resp_rdata;
                     end
                     state_q <= S_DONE;
                  end else begin
                     cnt_q   <= 8'd0;
                     state_q <= S_RESP;
                  end
               end
            end
            S_RESP: begin
               if (bus_resp_valid) begin
                  if (!write_q) begin
                     rdata_q <= bus_resp_rdata;
                  end
                  state_q <= S_DONE;
               end else if (cnt_d == TIMEOUT_LIM) begin
                  // The cycle that would bring the wait count up to the limit aborts the access.
                  rdata_q      <= 32'hDEAD_BEEF;
                  err_sticky_q <= 1'b1;
                  err_code_q   <= ERR_TIMEOUT;
                  state_q      <= S_DONE;
               end else begin
                  cnt_q <= cnt_d;
               end
            end
            S_DONE: begin
               state_q <= S_IDLE;
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   // The stall is combinational so the core freezes in the cycle the request appears.
   assign mem_busy = !reset &&
                     (((state_q == S_IDLE) && pending) ||
                      (state_q == S_REQ) || (state_q == S_RESP));

   assign bus_req_valid = (state_q == S_REQ);
   assign bus_req_addr  = addr_q;
   assign bus_req_write = write_q;
   assign bus_req_wdata = wdata_q;
   assign mem_read_data = rdata_q;
   assign err_sticky    = err_sticky_q;
   assign err_code      = err_code_q;
   assign dbg_state     = state_q;

endmodule

// File: tb/tb_data_mem_bridge.sv
// Directed bench for data_mem_bridge. Inputs change 1 ns after the rising
// edge. Outputs are sampled 1 ns after that, well away from the next edge.
module tb_data_mem_bridge;

   logic        clk;
   logic        reset;
   logic [31:0] data_addr;
   logic        should_read_mem;
   logic        should_write_mem;
   logic [31:0] mem_write_data;
   logic [31:0] mem_read_data;
   logic        mem_busy;
   logic        bus_req_valid;
   logic        bus_req_ready;
   logic [31:0] bus_req_addr;
   logic        bus_req_write;
   logic [31:0] bus_req_wdata;
   logic        bus_resp_valid;
   logic [31:0] bus_resp_rdata;
   logic        err_sticky;
   logic [1:0]  err_code;
   logic [1:0]  dbg_state;

   int passed;
   int total;

   data_mem_bridge #(.TIMEOUT_CYCLES(4)) dut (
      .clk              (clk),
      .reset            (reset),
      .data_addr        (data_addr),
      .should_read_mem  (should_read_mem),
      .should_write_mem (should_write_mem),
      .mem_write_data   (mem_write_data),
      .mem_read_data    (mem_read_data),
      .mem_busy         (mem_busy),
      .bus_req_valid    (bus_req_valid),
      .bus_req_ready    (bus_req_ready),
      .bus_req_addr     (bus_req_addr),
      .bus_req_write    (bus_req_write),
      .bus_req_wdata    (bus_req_wdata),
      .bus_resp_valid   (bus_resp_valid),
      .bus_resp_rdata   (bus_resp_rdata),
      .err_sticky       (err_sticky),
      .err_code         (err_code),
      .dbg_state        (dbg_state)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // driver tasks
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic core_req(input logic rd, input logic wr, input logic [31:0] addr,
                           input logic [31:0] wdata);
      should_read_mem  = rd;
      should_write_mem = wr;
      data_addr        = addr;
      mem_write_data   = wdata;
   endtask

   task automatic bus_drive(input logic rdy, input logic rv, input logic [31:0] rdata);
      bus_req_ready  = rdy;
      bus_resp_valid = rv;
      bus_resp_rdata = rdata;
   endtask

   // checker
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   initial begin
      passed = 0;
      total  = 0;
      reset  = 1'b1;
      core_req(1'b0, 1'b0, 32'd0, 32'd0);
      bus_drive(1'b0, 1'b0, 32'd0);
      tick();
      tick();

      // ---- reset state; busy stays low under reset even with a request ----
      core_req(1'b1, 1'b0, 32'h100, 32'd0);
      settle();
      chk("rst_state", 32'(dbg_state), 32'd0);
      chk("rst_rdata", mem_read_data, 32'd0);
      chk("rst_busy_with_req", 32'(mem_busy), 32'd0);
      chk("rst_valid", 32'(bus_req_valid), 32'd0);
      chk("rst_err", {29'd0, err_sticky, err_code}, 32'd0);

      // ---- aligned load 0x100 ----
      tick();                                    // cycle 0: IDLE
      reset = 1'b0;
      settle();
      chk("ld_c0_busy", 32'(mem_busy), 32'd1);
      chk("ld_c0_valid", 32'(bus_req_valid), 32'd0);
      tick();                                    // cycle 1: REQ
      bus_drive(1'b1, 1'b0, 32'd0);
      settle();
      chk("ld_c1_valid", 32'(bus_req_valid), 32'd1);
      chk("ld_c1_addr", bus_req_addr, 32'h100);
      chk("ld_c1_write", 32'(bus_req_write), 32'd0);
      chk("ld_c1_busy", 32'(mem_busy), 32'd1);
      tick();                                    // cycle 2: RESP
      bus_drive(1'b0, 1'b0, 32'd0);
      settle();
      chk("ld_c2_valid", 32'(bus_req_valid), 32'd0);
      chk("ld_c2_busy", 32'(mem_busy), 32'd1);
      tick();                                    // cycle 3: RESP + response
      bus_drive(1'b0, 1'b1, 32'hCAFE_F00D);
      settle();
      chk("ld_c3_busy", 32'(mem_busy), 32'd1);
      tick();                                    // cycle 4: DONE
      bus_drive(1'b0, 1'b0, 32'd0);
      core_req(1'b0, 1'b0, 32'd0, 32'd0);
      settle();
      chk("ld_c4_state", 32'(dbg_state), 32'd3);
      chk("ld_c4_busy", 32'(mem_busy), 32'd0);
      chk("ld_c4_rdata", mem_read_data, 32'hCAFE_F00D);
      tick();                                    // cycle 5: IDLE
      chk("ld_c5_state", 32'(dbg_state), 32'd0);

      // ---- stray response in IDLE is ignored ----
      bus_drive(1'b0, 1'b1, 32'hFFFF_FFFF);
      tick();
      bus_drive(1'b0, 1'b0, 32'd0);
      settle();
      chk("idle_resp_state", 32'(dbg_state), 32'd0);
      chk("idle_resp_rdata", mem_read_data, 32'hCAFE_F00D);

      // ---- store 0x204, ready low for 4 REQ cycles ----
      core_req(1'b0, 1'b1, 32'h204, 32'h1234_5678);
      tick();                                    // REQ
      for (int i = 0; i < 4; i++) begin
         // response without handshake must not move the FSM
         bus_drive(1'b0, (i == 1), 32'h5555_AAAA);
         settle();
         chk("st_req_state", 32'(dbg_state), 32'd1);
         chk("st_req_valid", 32'(bus_req_valid), 32'd1);
         chk("st_req_addr", bus_req_addr, 32'h204);
         chk("st_req_wdata", bus_req_wdata, 32'h1234_5678);
         chk("st_req_write", 32'(bus_req_write), 32'd1);
         tick();
      end
      bus_drive(1'b1, 1'b0, 32'd0);              // fifth REQ cycle: handshake
      settle();
      chk("st_hs_valid", 32'(bus_req_valid), 32'd1);
      tick();                                    // RESP
      bus_drive(1'b0, 1'b1, 32'h9999_9999);
      settle();
      chk("st_resp_state", 32'(dbg_state), 32'd2);
      tick();                                    // DONE
      bus_drive(1'b0, 1'b0, 32'd0);
      core_req(1'b0, 1'b0, 32'd0, 32'd0);
      settle();
      chk("st_done_state", 32'(dbg_state), 32'd3);
      chk("st_done_busy", 32'(mem_busy), 32'd0);
      chk("st_done_rdata", mem_read_data, 32'hCAFE_F00D);
      tick();                                    // IDLE

      // ---- misaligned load 0x103 ----
      core_req(1'b1, 1'b0, 32'h103, 32'd0);
      settle();
      chk("mis_c0_busy", 32'(mem_busy), 32'd1);
      chk("mis_c0_valid", 32'(bus_req_valid), 32'd0);
      tick();                                    // DONE
      core_req(1'b0, 1'b0, 32'd0, 32'd0);
      settle();
      chk("mis_state", 32'(dbg_state), 32'd3);
      chk("mis_valid", 32'(bus_req_valid), 32'd0);
      chk("mis_busy", 32'(mem_busy), 32'd0);
      chk("mis_rdata", mem_read_data, 32'd0);
      chk("mis_sticky", 32'(err_sticky), 32'd1);
      chk("mis_code", 32'(err_code), 32'd1);
      tick();

      // ---- timeout: load 0x8, no response ----
      core_req(1'b1, 1'b0, 32'h8, 32'd0);
      tick();                                    // REQ
      bus_drive(1'b1, 1'b0, 32'd0);
      tick();                                    // RESP cycle 1
      bus_drive(1'b0, 1'b0, 32'd0);
      for (int i = 0; i < 4; i++) begin
         settle();
         chk("to_resp_state", 32'(dbg_state), 32'd2);
         chk("to_resp_busy", 32'(mem_busy), 32'd1);
         tick();
      end
      core_req(1'b0, 1'b0, 32'd0, 32'd0);
      settle();
      chk("to_done_state", 32'(dbg_state), 32'd3);
      chk("to_done_busy", 32'(mem_busy), 32'd0);
      chk("to_rdata", mem_read_data, 32'hDEAD_BEEF);
      chk("to_code", 32'(err_code), 32'd2);
      chk("to_sticky", 32'(err_sticky), 32'd1);
      tick();

      // ---- load 0x10, ready and response together: REQ straight to DONE ----
      core_req(1'b1, 1'b0, 32'h10, 32'd0);
      tick();                                    // REQ
      bus_drive(1'b1, 1'b1, 32'h1357_9BDF);
      tick();                                    // DONE
      bus_drive(1'b0, 1'b0, 32'd0);
      core_req(1'b0, 1'b0, 32'd0, 32'd0);
      settle();
      chk("fast_state", 32'(dbg_state), 32'd3);
      chk("fast_busy", 32'(mem_busy), 32'd0);
      chk("fast_rdata", mem_read_data, 32'h1357_9BDF);
      chk("fast_sticky", 32'(err_sticky), 32'd1);
      chk("fast_code", 32'(err_code), 32'd2);
      tick();

      // ---- read and write both high at 0x40: store wins ----
      core_req(1'b1, 1'b1, 32'h40, 32'hA5A5_0F0F);
      tick();                                    // REQ
      bus_drive(1'b1, 1'b0, 32'd0);
      settle();
      chk("both_write", 32'(bus_req_write), 32'd1);
      chk("both_addr", bus_req_addr, 32'h40);
      chk("both_wdata", bus_req_wdata, 32'hA5A5_0F0F);
      tick();                                    // RESP
      bus_drive(1'b0, 1'b1, 32'h0000_0001);
      tick();                                    // DONE
      bus_drive(1'b0, 1'b0, 32'd0);
      core_req(1'b0, 1'b0, 32'd0, 32'd0);
      settle();
      chk("both_rdata", mem_read_data, 32'h1357_9BDF);
      tick();

      // ---- reset while in RESP, late response afterwards ----
      core_req(1'b1, 1'b0, 32'h20, 32'h7777_8888);
      tick();                                    // REQ
      bus_drive(1'b1, 1'b0, 32'd0);
      tick();                                    // RESP
      bus_drive(1'b0, 1'b0, 32'd0);
      reset = 1'b1;
      settle();
      chk("mid_rst_busy", 32'(mem_busy), 32'd0);
      tick();                                    // reset applied
      reset = 1'b0;
      core_req(1'b0, 1'b0, 32'd0, 32'd0);
      bus_drive(1'b0, 1'b1, 32'hAAAA_5555);
      settle();
      chk("post_rst_state", 32'(dbg_state), 32'd0);
      chk("post_rst_rdata", mem_read_data, 32'd0);
      chk("post_rst_valid", 32'(bus_req_valid), 32'd0);
      chk("post_rst_addr", bus_req_addr, 32'd0);
      chk("post_rst_write", 32'(bus_req_write), 32'd0);
      chk("post_rst_wdata", bus_req_wdata, 32'd0);
      chk("post_rst_err", {29'd0, err_sticky, err_code}, 32'd0);
      tick();
      bus_drive(1'b0, 1'b0, 32'd0);
      settle();
      chk("late_resp_state", 32'(dbg_state), 32'd0);
      chk("late_resp_rdata", mem_read_data, 32'd0);
      chk("late_resp_busy", 32'(mem_busy), 32'd0);

      // final report
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/data_mem_bridge.md
DATA_MEM_BRIDGE -- requirements
Module: data_mem_bridge

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, 255, max cycles waiting for a bus response before abort (1..255).
REQ-002 clk  in  1  single clock; all state updates on posedge.
REQ-003 reset  in  1  synchronous, active-high.
REQ-004 data_addr  in  32  core data address.
REQ-005 should_read_mem  in  1  core load request, level, held until mem_busy low.
REQ-006 should_write_mem  in  1  core store request, level, held until mem_busy low.
REQ-007 mem_write_data  in  32  core store data.
REQ-008 mem_read_data  out  32  load result returned to core.
REQ-009 mem_busy  out  1  core stall; PC and register writes frozen while high.
REQ-010 bus_req_valid  out  1  bus request valid.
REQ-011 bus_req_ready  in  1  bus accepts request when valid&ready.
REQ-012 bus_req_addr  out  32  word-aligned request address.
REQ-013 bus_req_write  out  1  1=store, 0=load.
REQ-014 bus_req_wdata  out  32  store data.
REQ-015 bus_resp_valid  in  1  one-cycle response pulse; completes load or store.
REQ-016 bus_resp_rdata  in  32  load data, valid with bus_resp_valid.
REQ-017 err_sticky  out  1  set on any error, cleared only by reset.
REQ-018 err_code  out  2  last error: 00 none, 01 misaligned, 10 timeout.

Function
REQ-019 The block SHALL implement FSM states IDLE, REQ, RESP, DONE.
REQ-020 The block SHALL treat a request as pending when should_read_mem|should_write_mem; write SHALL win when both are high.
REQ-021 mem_busy SHALL equal (IDLE & pending) | REQ | RESP, combinationally, so the core stalls in the same cycle a request appears.
REQ-022 IDLE & pending & data_addr[1:0]==0 SHALL capture addr, write flag, wdata into holding registers and go to REQ.
REQ-023 IDLE & pending & data_addr[1:0]!=0 SHALL issue no bus request, set mem_read_data=0, err_sticky=1, err_code=01, and go to DONE.
REQ-024 In REQ, bus_req_valid SHALL be 1 with addr/write/wdata from holding registers, stable until valid&ready.
REQ-025 REQ & bus_req_ready SHALL go to RESP, or directly to DONE if bus_resp_valid is also high that cycle.
REQ-026 RESP & bus_resp_valid SHALL go to DONE, latching bus_resp_rdata into mem_read_data for loads; stores SHALL leave mem_read_data unchanged.
REQ-027 An 8-bit counter SHALL clear on entry to RESP, increment each RESP cycle without response, and on reaching TIMEOUT_CYCLES SHALL go to DONE with mem_read_data=32'hDEADBEEF, err_sticky=1, err_code=10.
REQ-028 DONE SHALL last exactly one cycle with mem_busy=0 (core retires) and SHALL then return to IDLE unconditionally; no request SHALL be issued in DONE.
REQ-029 bus_resp_valid in IDLE, REQ-without-handshake, or DONE SHALL be ignored.
REQ-030 mem_read_data SHALL hold its last value outside DONE transitions.
REQ-031 bus_req_valid SHALL be 0 in all states except REQ; request latency from core request to bus_req_valid SHALL be 1 cycle.

Reset
REQ-032 reset SHALL force IDLE, counter=0, mem_read_data=0, bus_req_valid=0, bus_req_addr=0, bus_req_write=0, bus_req_wdata=0, err_sticky=0, err_code=00.
REQ-033 reset asserted mid-transaction SHALL abandon it; a late bus_resp_valid after reset SHALL be ignored per REQ-029.
REQ-034 mem_busy SHALL be 0 during reset regardless of request inputs.

Verification
REQ-035 Load addr 0x100, ready=1 at cycle 1, resp_valid with rdata 0xCAFEF00D at cycle 3 -> busy high cycles 0-3, bus_req_valid cycle 1 only, mem_read_data=0xCAFEF00D and busy=0 at cycle 4, IDLE at 5.
REQ-036 Store addr 0x204 data 0x12345678, ready held low 4 cycles -> bus_req_valid/addr/wdata/write=1 stable all 4 cycles, completes on resp, mem_read_data unchanged.
REQ-037 Load addr 0x103 -> no bus_req_valid, busy high 1 cycle, DONE with mem_read_data=0, err_sticky=1, err_code=01.
REQ-038 TIMEOUT_CYCLES=4, load accepted, no response -> DONE after 4 RESP cycles, mem_read_data=0xDEADBEEF, err_code=10; later valid load clears busy normally, err_sticky stays 1.
REQ-039 Read and write both high, addr 0x40 -> bus_req_write=1; separately, resp_valid in same cycle as ready -> REQ straight to DONE.
REQ-040 reset pulsed while in RESP, then resp_valid next cycle -> state IDLE, all outputs at REQ-032 values, response ignored.
